// File: rtl/elink_tx_framer_pkg.sv
// ---------------------------------------------------------------------------
// elink_tx_pkg
// Shared definitions for the eLink transmit framer:
//   - FSM state encodings (legacy-compatible 3-bit constants)
//   - packet lengths and the burst address stride
//   - captured-transaction struct
//   - helpers that build the header byte and pick a byte out of a word
// ---------------------------------------------------------------------------
package elink_tx_pkg;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] HDR  = 3'd1;
   localparam logic [2:0] ADDR = 3'd2;
   localparam logic [2:0] DATA = 3'd3;
   localparam logic [2:0] SRC  = 3'd4;

   localparam int WR_PKT_BYTES = 9;
   localparam int RD_PKT_BYTES = 13;
   localparam int ADDR_STRIDE  = 4;

   typedef struct packed {
      logic        write;
      logic [1:0]  datamode;
      logic [3:0]  ctrlmode;
      logic [31:0] dstaddr;
      logic [31:0] data;
      logic [31:0] srcaddr;
   } txn_t;

   // Header byte: {CTRLMODE, WRITE, DATAMODE, 0}
   function automatic logic [7:0] packHeader(input logic [3:0] ctrl,
                                             input logic       write,
                                             input logic [1:0] dm);
      return {ctrl, write, dm, 1'b0};
   endfunction

   // Words go out MSB first, so index 0 selects bits [31:24]
   function automatic logic [7:0] wordByte(input logic [31:0] w,
                                           input logic [1:0]  idx);
      logic [7:0] b;
      b = w[7:0];
      case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/elink_tx_framer_if.sv
// ---------------------------------------------------------------------------
// elink_tx_framer_if
// Transaction handshake bus from the fabric source into the TX framer.
//   IN_VALID / IN_READY       : handshake, transfer when both high
//   IN_WRITE                  : 1 = write packet, 0 = read packet
//   IN_DATAMODE / IN_CTRLMODE : passed through in the header byte
//   IN_DSTADDR / IN_DATA / IN_SRCADDR : packet payload words
// master = transaction source, slave = framer.
// ---------------------------------------------------------------------------
interface elink_tx_framer_if;

   logic        IN_VALID;
   logic        IN_READY;
   logic        IN_WRITE;
   logic [1:0]  IN_DATAMODE;
   logic [3:0]  IN_CTRLMODE;
   logic [31:0] IN_DSTADDR;
   logic [31:0] IN_DATA;
   logic [31:0] IN_SRCADDR;

   modport master (
      output IN_VALID, IN_WRITE, IN_DATAMODE, IN_CTRLMODE,
             IN_DSTADDR, IN_DATA, IN_SRCADDR,
      input  IN_READY
   );

   modport slave (
      input  IN_VALID, IN_WRITE, IN_DATAMODE, IN_CTRLMODE,
             IN_DSTADDR, IN_DATA, IN_SRCADDR,
      output IN_READY
   );

endinterface

// File: rtl/elink_tx_framer_sync.sv
// ---------------------------------------------------------------------------
// elink_sync2
// Multi-flop synchroniser for an asynchronous level input.
//   clk_i   : destination clock
//   rst_n_i : synchronous active-low reset, clears the chain
//   d_i     : asynchronous input
//   q_o     : synchronised output, SYNC_STAGES cycles of latency
// ---------------------------------------------------------------------------
module elink_sync2 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift the async level through the chain; only the last flop is used
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/elink_tx_framer.sv
// ---------------------------------------------------------------------------
// elink_tx_framer
// eLink transmit framer: accepts one transaction per handshake and sends it
// byte-wide with TX_FRAME high for the packet duration. Write packets are
// 9 bytes (header, dst, data), read packets 13 bytes (header, dst, zero
// data, src). Remote wait inputs block acceptance of new packets only.
//
// Ports:
//   CLK        : byte clock, rising edge
//   RESET_N    : synchronous active-low reset
//   inBus      : transaction handshake bus (slave side)
//   TX_WR_WAIT : remote write wait, asynchronous
//   TX_RD_WAIT : remote read wait, asynchronous
//   TX_DATA    : registered byte to serialiser
//   TX_FRAME   : registered, high while packet bytes are valid
//   BUSY       : packet in progress
//   PKT_COUNT  : completed packets, wraps
//
// Build option: define ELINK_TX_BURST_EN to allow a contiguous write to
// follow the previous write directly with only its 4 data bytes.
// ---------------------------------------------------------------------------
module elink_tx_framer
   import elink_tx_pkg::*;
#(
   parameter int PKT_CNT_W   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   elink_tx_framer_if.slave     inBus,
   input  logic                 TX_WR_WAIT,
   input  logic                 TX_RD_WAIT,
   output logic [7:0]           TX_DATA,
   output logic                 TX_FRAME,
   output logic                 BUSY,
   output logic [PKT_CNT_W-1:0] PKT_COUNT
);

   logic [2:0]           state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   txn_t                 hold_q, hold_d;
   logic [7:0]           txData_q, txData_d;
   logic                 txFrame_q, txFrame_d;
   logic [PKT_CNT_W-1:0] pktCount_q, pktCount_d;

   logic wrWaitS;
   logic rdWaitS;
   logic idleReady;
   logic inReady;
   logic accept;
   logic burstTake;
   txn_t inTxn;

   elink_sync2 #(.SYNC_STAGES(SYNC_STAGES)) uWrWaitSync (
      .clk_i   (CLK),
      .rst_n_i (RESET_N),
      .d_i     (TX_WR_WAIT),
      .q_o     (wrWaitS)
   );

   elink_sync2 #(.SYNC_STAGES(SYNC_STAGES)) uRdWaitSync (
      .clk_i   (CLK),
      .rst_n_i (RESET_N),
      .d_i     (TX_RD_WAIT),
      .q_o     (rdWaitS)
   );

   assign inTxn = '{write:    inBus.IN_WRITE,
                    datamode: inBus.IN_DATAMODE,
                    ctrlmode: inBus.IN_CTRLMODE,
                    dstaddr:  inBus.IN_DSTADDR,
                    data:     inBus.IN_DATA,
                    srcaddr:  inBus.IN_SRCADDR};

   // Normal acceptance depends only on registered state and synced waits
   assign idleReady = (state_q == IDLE) && !wrWaitS && !rdWaitS;

`ifdef ELINK_TX_BURST_EN
   logic burstReady;

   // Burst continuation: this term looks at the incoming IN_* fields, so
   // IN_READY has a combinational path from the bus in this build
   assign burstReady = (state_q == DATA) && (idx_q == 2'd3) && hold_q.write &&
                       inBus.IN_WRITE &&
                       (inBus.IN_CTRLMODE == hold_q.ctrlmode) &&
                       (inBus.IN_DATAMODE == hold_q.datamode) &&
                       (inBus.IN_DSTADDR == hold_q.dstaddr + 32'(ADDR_STRIDE)) &&
                       !wrWaitS && !rdWaitS;
   assign inReady   = idleReady || burstReady;
   assign burstTake = accept && (state_q == DATA);
`else
   assign inReady   = idleReady;
   assign burstTake = 1'b0;
`endif

   assign accept         = inBus.IN_VALID && inReady;
   assign inBus.IN_READY = inReady;

   // Next-state and output-byte selection. The byte chosen for the current
   // state is registered, so TX_DATA lags the state by one cycle; IDLE
   // produces the zero/frame-low gap byte.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      pktCount_d = pktCount_q;
      txData_d   = 8'h00;
      txFrame_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = HDR;
               hold_d  = inTxn;
            end
         end
         HDR: begin
            txData_d  = packHeader(hold_q.ctrlmode, hold_q.write, hold_q.datamode);
            txFrame_d = 1'b1;
            idx_d     = 2'd0;
            state_d   = ADDR;
         end
         ADDR: begin
            txData_d  = wordByte(hold_q.dstaddr, idx_q);
            txFrame_d = 1'b1;
            idx_d     = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = DATA;
            end
         end
         DATA: begin
            txData_d  = hold_q.write ? wordByte(hold_q.data, idx_q) : 8'h00;
            txFrame_d = 1'b1;
            idx_d     = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               if (!hold_q.write) begin
                  state_d = SRC;
               end else begin
                  pktCount_d = pktCount_q + PKT_CNT_W'(1);
                  if (burstTake) begin
                     state_d = DATA;
                     hold_d  = inTxn;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         SRC: begin
            txData_d  = wordByte(hold_q.srcaddr, idx_q);
            txFrame_d = 1'b1;
            idx_d     = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               pktCount_d = pktCount_q + PKT_CNT_W'(1);
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, holding register and registered outputs; reset aborts any
   // packet in flight without counting it
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         idx_q      <= 2'd0;
         hold_q     <= '0;
         txData_q   <= 8'h00;
         txFrame_q  <= 1'b0;
         pktCount_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         txData_q   <= txData_d;
         txFrame_q  <= txFrame_d;
         pktCount_q <= pktCount_d;
      end
   end

   assign TX_DATA   = txData_q;
   assign TX_FRAME  = txFrame_q;
   assign BUSY      = (state_q != IDLE);
   assign PKT_COUNT = pktCount_q;

endmodule

// File: tb/tb_elink_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_elink_tx_framer
// Directed bench for elink_tx_framer: reset, single write, read, wait
// back-pressure, back-to-back writes and reset in mid-packet.
// ---------------------------------------------------------------------------
module tb_elink_tx_framer;

   logic        CLK;
   logic        RESET_N;
   logic        TX_WR_WAIT;
   logic        TX_RD_WAIT;
   logic [7:0]  TX_DATA;
   logic        TX_FRAME;
   logic        BUSY;
   logic [15:0] PKT_COUNT;

   int checks;
   int errors;
   int expCount;

   logic [7:0]  capData  [32];
   logic        capFrame [32];
   logic [15:0] capCount [32];

   elink_tx_framer_if bus ();

   elink_tx_framer #(
      .PKT_CNT_W   (16),
      .SYNC_STAGES (2)
   ) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .inBus      (bus),
      .TX_WR_WAIT (TX_WR_WAIT),
      .TX_RD_WAIT (TX_RD_WAIT),
      .TX_DATA    (TX_DATA),
      .TX_FRAME   (TX_FRAME),
      .BUSY       (BUSY),
      .PKT_COUNT  (PKT_COUNT)
   );

   // 10 ns byte clock; the bench drives and samples on falling edges
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Offer a transaction and hold it until accepted (bounded); returns at
   // the falling edge after the accepting rising edge with IN_VALID dropped
   task automatic applyStimulus(input logic wr, input logic [1:0] dm,
                                input logic [3:0] ctrl, input logic [31:0] dst,
                                input logic [31:0] data, input logic [31:0] src,
                                output bit ok);
      ok               = 1'b0;
      bus.IN_VALID     = 1'b1;
      bus.IN_WRITE     = wr;
      bus.IN_DATAMODE  = dm;
      bus.IN_CTRLMODE  = ctrl;
      bus.IN_DSTADDR   = dst;
      bus.IN_DATA      = data;
      bus.IN_SRCADDR   = src;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (bus.IN_READY) begin
            @(posedge CLK);
            ok = 1'b1;
         end else begin
            @(negedge CLK);
         end
      end
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
   endtask

   // Record n consecutive output samples, one per falling edge
   task automatic captureFrame(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         capData[k]  = TX_DATA;
         capFrame[k] = TX_FRAME;
         capCount[k] = PKT_COUNT;
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (TX_FRAME !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_frame: got %b expected 0", TX_FRAME);
      end
      checks++;
      if (TX_DATA !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_data: got %h expected 00", TX_DATA);
      end
      checks++;
      if (PKT_COUNT !== 16'd0) begin
         errors++;
         $display("[TB] FAIL reset_count: got %0d expected 0", PKT_COUNT);
      end
      checks++;
      if (BUSY !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %b expected 0", BUSY);
      end
      RESET_N = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.IN_READY !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b expected 1", bus.IN_READY);
      end
      expCount = 0;
   endtask

   task automatic test_write();
      logic [7:0] exp [9];
      bit ok;
      exp = '{8'h0C, 8'h80, 8'h80, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      applyStimulus(1'b1, 2'd2, 4'h0, 32'h8080_0000, 32'hDEAD_BEEF, 32'h0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL write_accept: got no handshake expected handshake");
      end
      captureFrame(10);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (capData[k] !== exp[k] || capFrame[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_byte%0d: got %h/%b expected %h/1",
                     k, capData[k], capFrame[k], exp[k]);
         end
      end
      checks++;
      if (capFrame[9] !== 1'b0 || capData[9] !== 8'h00) begin
         errors++;
         $display("[TB] FAIL write_gap: got %h/%b expected 00/0", capData[9], capFrame[9]);
      end
      expCount++;
      checks++;
      if (capCount[7] !== 16'(expCount - 1) || capCount[8] !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL write_count: got %0d,%0d expected %0d,%0d",
                  capCount[7], capCount[8], expCount - 1, expCount);
      end
   endtask

   task automatic test_read();
      logic [7:0] exp [13];
      bit ok;
      // header {0000, 0, 10, 0} = 0x04
      exp = '{8'h04, 8'h80, 8'h80, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h81, 8'h00, 8'h00, 8'h20};
      applyStimulus(1'b0, 2'd2, 4'h0, 32'h8080_0010, 32'hFFFF_FFFF, 32'h8100_0020, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL read_accept: got no handshake expected handshake");
      end
      captureFrame(14);
      for (int k = 0; k < 13; k++) begin
         checks++;
         if (capData[k] !== exp[k] || capFrame[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL read_byte%0d: got %h/%b expected %h/1",
                     k, capData[k], capFrame[k], exp[k]);
         end
      end
      checks++;
      if (capFrame[13] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_gap: got %b expected 0", capFrame[13]);
      end
      expCount++;
      checks++;
      if (PKT_COUNT !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL read_count: got %0d expected %0d", PKT_COUNT, expCount);
      end
   endtask

   task automatic test_wait();
      logic [7:0] exp [9];
      logic [7:0] exp2 [9];
      bit ok;
      // header {0101, 1, 01, 0} = 0x5A
      exp  = '{8'h5A, 8'h00, 8'h00, 8'h02, 8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      // header {0000, 1, 00, 0} = 0x08
      exp2 = '{8'h08, 8'h00, 8'h00, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(1'b1, 2'd1, 4'h5, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL wait_accept: got no handshake expected handshake");
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         capData[k]  = TX_DATA;
         capFrame[k] = TX_FRAME;
         if (k == 3) TX_WR_WAIT = 1'b1;
      end
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (capData[k] !== exp[k] || capFrame[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_byte%0d: got %h/%b expected %h/1",
                     k, capData[k], capFrame[k], exp[k]);
         end
      end
      expCount++;
      // queue a new write while the wait is held
      bus.IN_VALID    = 1'b1;
      bus.IN_WRITE    = 1'b1;
      bus.IN_DATAMODE = 2'd0;
      bus.IN_CTRLMODE = 4'h0;
      bus.IN_DSTADDR  = 32'h0000_0300;
      bus.IN_DATA     = 32'h0102_0304;
      bus.IN_SRCADDR  = 32'h0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.IN_READY !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_hold%0d: got ready %b expected 0", k, bus.IN_READY);
         end
         @(negedge CLK);
      end
      TX_WR_WAIT = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.IN_READY !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_release1: got ready %b expected 0", bus.IN_READY);
      end
      @(negedge CLK);
      checks++;
      if (bus.IN_READY !== 1'b1) begin
         errors++;
         $display("[TB] FAIL wait_release2: got ready %b expected 1", bus.IN_READY);
      end
      @(posedge CLK);
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
      captureFrame(10);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (capData[k] !== exp2[k] || capFrame[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL queued_byte%0d: got %h/%b expected %h/1",
                     k, capData[k], capFrame[k], exp2[k]);
         end
      end
      expCount++;
      checks++;
      if (PKT_COUNT !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL wait_count: got %0d expected %0d", PKT_COUNT, expCount);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e1 [9];
      logic [7:0] e2 [9];
      logic [7:0] expData [20];
      logic       expFrame [20];
      int         nSamp;
      bit         ok1;
      bit         ok2;
      e1 = '{8'h0C, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      e2 = '{8'h0C, 8'h00, 8'h00, 8'h01, 8'h04, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int k = 0; k < 20; k++) begin
         expData[k]  = 8'h00;
         expFrame[k] = 1'b0;
      end
      for (int k = 0; k < 9; k++) begin
         expData[k]  = e1[k];
         expFrame[k] = 1'b1;
      end
`ifdef ELINK_TX_BURST_EN
      for (int k = 0; k < 4; k++) begin
         expData[9+k]  = e2[5+k];
         expFrame[9+k] = 1'b1;
      end
      nSamp = 14;
`else
      for (int k = 0; k < 9; k++) begin
         expData[10+k]  = e2[k];
         expFrame[10+k] = 1'b1;
      end
      nSamp = 20;
`endif
      applyStimulus(1'b1, 2'd2, 4'h0, 32'h0000_0100, 32'h1122_3344, 32'h0, ok1);
      fork
         applyStimulus(1'b1, 2'd2, 4'h0, 32'h0000_0104, 32'h5566_7788, 32'h0, ok2);
         captureFrame(nSamp);
      join
      checks++;
      if (!ok1 || !ok2) begin
         errors++;
         $display("[TB] FAIL b2b_accept: got %b%b expected 11", ok1, ok2);
      end
      for (int k = 0; k < nSamp; k++) begin
         checks++;
         if (capFrame[k] !== expFrame[k] ||
             (expFrame[k] && capData[k] !== expData[k])) begin
            errors++;
            $display("[TB] FAIL b2b_byte%0d: got %h/%b expected %h/%b",
                     k, capData[k], capFrame[k], expData[k], expFrame[k]);
         end
      end
      expCount += 2;
      checks++;
      if (PKT_COUNT !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d expected %0d", PKT_COUNT, expCount);
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [7:0] exp [9];
      bit ok;
      exp = '{8'h0C, 8'h00, 8'h00, 8'h05, 8'h00, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
      // header {0001, 1, 11, 0} = 0x1E, B6 is the second data byte 0xA5
      applyStimulus(1'b1, 2'd3, 4'h1, 32'h0000_0400, 32'hA5A5_A5A5, 32'h0, ok);
      captureFrame(7);
      checks++;
      if (!ok || capData[0] !== 8'h1E || capData[6] !== 8'hA5 || capFrame[6] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_pre: got ok=%b b0=%h b6=%h/%b expected ok=1 b0=1e b6=a5/1",
                  ok, capData[0], capData[6], capFrame[6]);
      end
      RESET_N = 1'b0;
      @(negedge CLK);
      checks++;
      if (TX_FRAME !== 1'b0 || BUSY !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_frame: got frame %b busy %b expected 0 0", TX_FRAME, BUSY);
      end
      // reset clears the counter and the aborted packet is never counted
      checks++;
      if (PKT_COUNT !== 16'd0) begin
         errors++;
         $display("[TB] FAIL midrst_count: got %0d expected 0", PKT_COUNT);
      end
      RESET_N  = 1'b1;
      expCount = 0;
      @(negedge CLK);
      applyStimulus(1'b1, 2'd2, 4'h0, 32'h0000_0500, 32'h0BAD_F00D, 32'h0, ok);
      captureFrame(10);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (capData[k] !== exp[k] || capFrame[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL postrst_byte%0d: got %h/%b expected %h/1",
                     k, capData[k], capFrame[k], exp[k]);
         end
      end
      checks++;
      if (capFrame[9] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL postrst_gap: got %b expected 0", capFrame[9]);
      end
      expCount++;
      checks++;
      if (PKT_COUNT !== 16'(expCount)) begin
         errors++;
         $display("[TB] FAIL postrst_count: got %0d expected %0d", PKT_COUNT, expCount);
      end
   endtask

   // Guard against a stuck run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks          = 0;
      errors          = 0;
      expCount        = 0;
      RESET_N         = 1'b0;
      TX_WR_WAIT      = 1'b0;
      TX_RD_WAIT      = 1'b0;
      bus.IN_VALID    = 1'b0;
      bus.IN_WRITE    = 1'b0;
      bus.IN_DATAMODE = 2'd0;
      bus.IN_CTRLMODE = 4'h0;
      bus.IN_DSTADDR  = 32'h0;
      bus.IN_DATA     = 32'h0;
      bus.IN_SRCADDR  = 32'h0;
      @(negedge CLK);
      test_reset();
      test_write();
      test_read();
      test_wait();
      test_back_to_back();
      test_reset_mid_packet();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
